fix_session_ctrl: RTL and testbench

//  Sequences FIX session bring-up between the application, fix_engine and top_toe_fix.

---
 rtl/fix_ctrl_pkg.sv | 31 +++
 rtl/fix_timer.sv | 36 +++
 rtl/fix_session_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_fix_session_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_ctrl_pkg.sv
// fix_ctrl_pkg
//   Shared definitions for the FIX session controller:
//   - fix_state_e   : 3-bit state encodings (also exported on state_o for debug)
//   - HOST_W_DEFAULT: default host address width
//   - clog2max      : width of a down-counter able to hold (max of three lengths)-1
package fix_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STARTUP   = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_WAIT_CONN = 3'd3,
    ST_UP        = 3'd4,
    ST_BACKOFF   = 3'd5,
    ST_FAILED    = 3'd6
  } fix_state_e;

  localparam int HOST_W_DEFAULT = 2;

  // Counter width for the largest of three cycle counts. The counter is only
  // ever loaded with (count-1), so $clog2(max) bits suffice; at least 1 bit
  // is kept so the counter never collapses to zero width.
  function automatic int clog2max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fix_timer.sv
// fix_timer
//   Loadable down-counter shared by the STARTUP, WAIT_CONN and BACKOFF phases.
//   Saturates at zero; load takes priority over decrement.
// Ports
//   clk       in  1  clock
//   rst       in  1  asynchronous active-low reset (counter cleared)
//   load      in  1  load load_val this cycle
//   load_val  in  W  value to load
//   dec       in  1  decrement by one (ignored when already zero)
//   zero_o    out 1  counter equals zero
module fix_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fix_session_ctrl.sv
// fix_session_ctrl
//   FIX session bring-up controller between the application, fix_engine and
//   the TOE: startup delay, connect request with timeout, bounded retries with
//   backoff, link-drop recovery, and gating of fix_engine writes into the TOE
//   data FIFO.
// Ports
//   clk                    in  1        clock
//   rst                    in  1        asynchronous active-low reset
//   enable_i               in  1        run session (level); low forces IDLE
//   host_sel_i             in  HOST_W   target host, latched on IDLE->STARTUP
//   connect_o              out 1        one-cycle connect pulse per attempt
//   connect_to_host_o      out HOST_W   latched host, valid from REQUEST until IDLE
//   connected_i            in  1        TOE connection status
//   connected_host_addr_i  in  HOST_W   TOE connected host address
//   fifo_full_i            in  1        TOE data FIFO full
//   error_i                in  1        TOE data FIFO error
//   tx_allow_o             out 1        session up and FIFO not full (combinational)
//   session_up_o           out 1        session established
//   fail_o                 out 1        retries exhausted (sticky until disabled)
//   retry_cnt_o            out RETRY_W  retries used in this bring-up
//   state_o                out 3        current state encoding (debug)
module fix_session_ctrl
  import fix_ctrl_pkg::*;
#(
  parameter int STARTUP_CYCLES  = 100,
  parameter int CONNECT_TIMEOUT = 1024,
  parameter int MAX_RETRIES     = 3,
  parameter int BACKOFF_CYCLES  = 256,
  parameter int HOST_W          = HOST_W_DEFAULT,
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [HOST_W-1:0]  host_sel_i,
  output logic               connect_o,
  output logic [HOST_W-1:0]  connect_to_host_o,
  input  logic               connected_i,
  input  logic [HOST_W-1:0]  connected_host_addr_i,
  input  logic               fifo_full_i,
  input  logic               error_i,
  output logic               tx_allow_o,
  output logic               session_up_o,
  output logic               fail_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [2:0]         state_o
);

  localparam int TMR_W = clog2max(STARTUP_CYCLES, CONNECT_TIMEOUT, BACKOFF_CYCLES);

  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_STARTUP   = ST_STARTUP;
  localparam logic [2:0] S_REQUEST   = ST_REQUEST;
  localparam logic [2:0] S_WAIT_CONN = ST_WAIT_CONN;
  localparam logic [2:0] S_UP        = ST_UP;
  localparam logic [2:0] S_BACKOFF   = ST_BACKOFF;
  localparam logic [2:0] S_FAILED    = ST_FAILED;

  localparam logic [TMR_W-1:0]   LD_STARTUP = TMR_W'(STARTUP_CYCLES - 1);
  localparam logic [TMR_W-1:0]   LD_TIMEOUT = TMR_W'(CONNECT_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   LD_BACKOFF = TMR_W'(BACKOFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  logic [2:0]         state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [HOST_W-1:0]  host_lat_q, host_lat_d;
  logic [HOST_W-1:0]  host_out_q;
  logic               connect_q, up_q, fail_q;

  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;

  logic               host_match;

  assign host_match = connected_i && (connected_host_addr_i == host_lat_q);

  fix_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero_o   (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    host_lat_d = host_lat_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d    = S_STARTUP;
        host_lat_d = host_sel_i;
        tmr_load   = 1'b1;
        tmr_val    = LD_STARTUP;
      end
      S_STARTUP: begin
        if (tmr_zero) state_d = S_REQUEST;
        else          tmr_dec = 1'b1;
      end
      S_REQUEST: begin
        state_d  = S_WAIT_CONN;
        tmr_load = 1'b1;
        tmr_val  = LD_TIMEOUT;
      end
      S_WAIT_CONN: begin
        // A matching connection on the final timeout cycle still wins.
        if (host_match) begin
          state_d = S_UP;
        end else if (tmr_zero) begin
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAILED;
          end else begin
            state_d  = S_BACKOFF;
            retry_d  = retry_q + RETRY_W'(1);
            tmr_load = 1'b1;
            tmr_val  = LD_BACKOFF;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_UP: begin
        // A drop after a successful session starts a fresh retry budget.
        if (!connected_i || error_i) begin
          state_d  = S_BACKOFF;
          retry_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = LD_BACKOFF;
        end
      end
      S_BACKOFF: begin
        if (tmr_zero) state_d = S_REQUEST;
        else          tmr_dec = 1'b1;
      end
      S_FAILED: begin
        state_d = S_FAILED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disable overrides everything; the IDLE case above only runs when enabled.
    if (!enable_i) begin
      state_d  = S_IDLE;
      retry_d  = '0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
    end
  end

  // Outputs are registered from the next-state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      retry_q    <= '0;
      host_lat_q <= '0;
      host_out_q <= '0;
      connect_q  <= 1'b0;
      up_q       <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      host_lat_q <= host_lat_d;
      host_out_q <= ((state_d == S_IDLE) || (state_d == S_STARTUP)) ? '0 : host_lat_d;
      connect_q  <= (state_d == S_REQUEST);
      up_q       <= (state_d == S_UP);
      fail_q     <= (state_d == S_FAILED);
    end
  end

  assign state_o           = state_q;
  assign retry_cnt_o       = retry_q;
  assign connect_o         = connect_q;
  assign connect_to_host_o = host_out_q;
  assign session_up_o      = up_q;
  assign fail_o            = fail_q;
  // Zero-latency gate: a full FIFO blocks writes in the same cycle.
  assign tx_allow_o        = up_q & ~fifo_full_i;

endmodule

// File: tb/tb_fix_session_ctrl.sv
module tb_fix_session_ctrl;

  localparam int SC = 4;
  localparam int CT = 8;
  localparam int MR = 2;
  localparam int BC = 3;

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_REQ   = 2;
  localparam int P_WAIT  = 3;
  localparam int P_UP    = 4;
  localparam int P_BACK  = 5;
  localparam int P_FAIL  = 6;

  logic       clk;
  logic       rst;
  logic       enable_i;
  logic [1:0] host_sel_i;
  logic       connect_o;
  logic [1:0] connect_to_host_o;
  logic       connected_i;
  logic [1:0] connected_host_addr_i;
  logic       fifo_full_i;
  logic       error_i;
  logic       tx_allow_o;
  logic       session_up_o;
  logic       fail_o;
  logic [1:0] retry_cnt_o;
  logic [2:0] state_o;

  fix_session_ctrl #(
    .STARTUP_CYCLES  (SC),
    .CONNECT_TIMEOUT (CT),
    .MAX_RETRIES     (MR),
    .BACKOFF_CYCLES  (BC),
    .HOST_W          (2)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable_i              (enable_i),
    .host_sel_i            (host_sel_i),
    .connect_o             (connect_o),
    .connect_to_host_o     (connect_to_host_o),
    .connected_i           (connected_i),
    .connected_host_addr_i (connected_host_addr_i),
    .fifo_full_i           (fifo_full_i),
    .error_i               (error_i),
    .tx_allow_o            (tx_allow_o),
    .session_up_o          (session_up_o),
    .fail_o                (fail_o),
    .retry_cnt_o           (retry_cnt_o),
    .state_o               (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase plus cycles spent in that phase, compared
  // against the phase lengths directly.
  int m_phase;
  int m_age;
  int m_retry;
  int m_host;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_age   = 0;
    m_retry = 0;
    m_host  = 0;
  endtask

  task automatic model_edge();
    int nxt;
    nxt = m_phase;
    if (!enable_i) begin
      nxt     = P_IDLE;
      m_retry = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          nxt    = P_START;
          m_host = int'(host_sel_i);
        end
        P_START: if (m_age == SC) nxt = P_REQ;
        P_REQ:   nxt = P_WAIT;
        P_WAIT: begin
          if (connected_i && (int'(connected_host_addr_i) == m_host)) nxt = P_UP;
          else if (m_age == CT) begin
            if (m_retry == MR) nxt = P_FAIL;
            else begin
              m_retry++;
              nxt = P_BACK;
            end
          end
        end
        P_UP: begin
          if (!connected_i || error_i) begin
            m_retry = 0;
            nxt     = P_BACK;
          end
        end
        P_BACK: if (m_age == BC) nxt = P_REQ;
        default: ;
      endcase
    end
    if (nxt != m_phase) begin
      m_phase = nxt;
      m_age   = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_all(input string tag);
    int exp_host;
    exp_host = ((m_phase == P_IDLE) || (m_phase == P_START)) ? 0 : m_host;
    chk({tag, ".state"},   32'(state_o),           m_phase);
    chk({tag, ".connect"}, 32'(connect_o),         32'(m_phase == P_REQ));
    chk({tag, ".host"},    32'(connect_to_host_o), exp_host);
    chk({tag, ".up"},      32'(session_up_o),      32'(m_phase == P_UP));
    chk({tag, ".fail"},    32'(fail_o),            32'(m_phase == P_FAIL));
    chk({tag, ".retry"},   32'(retry_cnt_o),       m_retry);
    chk({tag, ".tx"},      32'(tx_allow_o),        32'((m_phase == P_UP) && !fifo_full_i));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Steps until connect_o is seen or limit steps elapse; n = steps taken.
  task automatic run_to_connect(input string tag, input int limit, output int n);
    n = 0;
    do begin
      step(tag);
      n++;
    end while ((connect_o !== 1'b1) && (n < limit));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses[$];
    int pulse_retry[$];
    int cnt;
    logic link;

    rst                   = 1'b0;
    enable_i              = 1'b0;
    host_sel_i            = 2'b00;
    connected_i           = 1'b0;
    connected_host_addr_i = 2'b00;
    fifo_full_i           = 1'b0;
    error_i               = 1'b0;
    model_reset();

    // Reset state
    #22;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    step("idle");

    // 1: startup, single connect pulse, connect to host 01
    enable_i   = 1'b1;
    host_sel_i = 2'b01;
    run_to_connect("t1", 20, n);
    chk("t1.latency", n, SC + 1);
    chk("t1.host", 32'(connect_to_host_o), 1);
    step("t1.req_end");
    chk("t1.one_cycle", 32'(connect_o), 0);
    connected_i           = 1'b1;
    connected_host_addr_i = 2'b01;
    step("t1.match");
    chk("t1.up", 32'(session_up_o), 1);
    chk("t1.tx", 32'(tx_allow_o), 1);

    // 2: no connection at all -> three attempts then FAILED
    enable_i    = 1'b0;
    connected_i = 1'b0;
    step("t2.dis");
    enable_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step("t2");
      if (connect_o === 1'b1) begin
        pulses.push_back(i);
        pulse_retry.push_back(int'(retry_cnt_o));
      end
    end
    chk("t2.npulse", pulses.size(), MR + 1);
    if (pulses.size() == MR + 1) begin
      for (int k = 1; k <= MR; k++) begin
        chk("t2.spacing", pulses[k] - pulses[k-1], 1 + CT + BC);
      end
      for (int k = 0; k <= MR; k++) begin
        chk("t2.pulse_retry", pulse_retry[k], k);
      end
    end
    chk("t2.fail", 32'(fail_o), 1);
    connected_i           = 1'b1;
    connected_host_addr_i = 2'b01;
    step("t2.late");
    chk("t2.sticky", 32'(fail_o), 1);
    connected_i = 1'b0;
    enable_i    = 1'b0;
    step("t2.off");
    chk("t2.off_fail", 32'(fail_o), 0);
    chk("t2.off_retry", 32'(retry_cnt_o), 0);
    chk("t2.off_state", 32'(state_o), P_IDLE);

    // 3: mismatched address ignored, then match on last timeout cycle
    enable_i              = 1'b1;
    connected_i           = 1'b1;
    connected_host_addr_i = 2'b10;
    run_to_connect("t3", 20, n);
    for (int i = 0; i < CT + 1; i++) step("t3.mis");
    chk("t3.backoff", 32'(state_o), P_BACK);
    chk("t3.retry", 32'(retry_cnt_o), 1);
    run_to_connect("t3.b", 10, n);
    chk("t3.backoff_len", n, BC);
    connected_i = 1'b0;
    for (int i = 0; i < CT; i++) step("t3.wait");
    connected_i           = 1'b1;
    connected_host_addr_i = 2'b01;
    step("t3.last");
    chk("t3.up_last", 32'(session_up_o), 1);

    // 4: fifo full gating and error recovery
    fifo_full_i = 1'b1;
    #1;
    chk("t4.tx_full", 32'(tx_allow_o), 0);
    fifo_full_i = 1'b0;
    #1;
    chk("t4.tx_free", 32'(tx_allow_o), 1);
    error_i = 1'b1;
    step("t4.err");
    error_i = 1'b0;
    chk("t4.state", 32'(state_o), P_BACK);
    chk("t4.retry", 32'(retry_cnt_o), 0);
    run_to_connect("t4.b", 10, n);
    chk("t4.reconnect", n, BC);

    // 5: asynchronous reset in WAIT_CONN, then full restart
    connected_i = 1'b0;
    step("t5.w0");
    step("t5.w1");
    step("t5.w2");
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t5.rst");
    #2;
    rst = 1'b1;
    run_to_connect("t5", 20, n);
    chk("t5.latency", n, SC + 1);

    // 6: disable during BACKOFF, no further attempts
    cnt = 0;
    while ((m_phase != P_BACK) && (cnt < 30)) begin
      step("t6.to_back");
      cnt++;
    end
    chk("t6.in_backoff", 32'(state_o), P_BACK);
    enable_i = 1'b0;
    step("t6.off");
    chk("t6.idle", 32'(state_o), P_IDLE);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step("t6.quiet");
      if (connect_o === 1'b1) cnt++;
    end
    chk("t6.no_pulse", cnt, 0);

    // Randomized traffic against the model
    link = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      enable_i    = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) link = ~link;
      if ($urandom_range(0, 9) == 0) connected_host_addr_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) host_sel_i = 2'($urandom_range(0, 3));
      connected_i = link;
      error_i     = ($urandom_range(0, 31) == 0);
      fifo_full_i = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
